// File: rtl/store_monitor.sv
// store_monitor
// End-of-test checker on the data-memory write port of the RISC-V core.
// Every store is classified as the pass signature, an allowed scratch store
// or an illegal store, and a watchdog catches programs that never store the
// signature. Verdict flags are sticky until reset; diagnostics record the
// first illegal store and how long the program ran.
module store_monitor #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] PASS_ADDR   = WIDTH'(100),
   parameter logic [WIDTH-1:0] PASS_DATA   = WIDTH'(25),
   parameter logic [WIDTH-1:0] SCRATCH_LO  = WIDTH'(96),
   parameter logic [WIDTH-1:0] SCRATCH_HI  = WIDTH'(96),
   parameter bit               ALIGN_CHECK = 1'b1,
   parameter int unsigned      TIMEOUT     = 1000,
   parameter int unsigned      CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemWrite,
   input  logic [WIDTH-1:0] DataAddr,
   input  logic [WIDTH-1:0] WriteData,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [CNT_W-1:0] store_count,
   output logic [CNT_W-1:0] cycle_count,
   output logic [WIDTH-1:0] fail_addr,
   output logic [WIDTH-1:0] fail_data
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PASS = 2'd1,
      FAIL = 2'd2,
      TMO  = 2'd3
   } state_t;

   // A watchdog limit above what the saturating counter can reach would
   // otherwise alias onto a smaller count after truncation, so it is treated
   // as never expiring.
   localparam longint unsigned CNT_MAX   = (64'd1 << CNT_W) - 64'd1;
   localparam bit              WD_ENABLE = (TIMEOUT != 0) && (longint'(TIMEOUT) <= CNT_MAX);
   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cycle_inc;
   logic [CNT_W-1:0] store_inc;
   logic             misaligned;
   logic             in_scratch;

   // Saturating counter increments, store classification and watchdog
   // expiry; a store verdict on the edge the watchdog expires takes priority.
   always_comb begin
      cycle_inc  = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
      store_inc  = (store_count == '1) ? store_count : store_count + 1'b1;
      misaligned = ALIGN_CHECK && (DataAddr[1:0] != 2'b00);
      in_scratch = (DataAddr >= SCRATCH_LO) && (DataAddr <= SCRATCH_HI);
      next_state = RUN;
      if (MemWrite) begin
         if (misaligned)
            next_state = FAIL;
         else if (DataAddr == PASS_ADDR)
            next_state = (WriteData == PASS_DATA) ? PASS : FAIL;
         else if (in_scratch)
            next_state = RUN;
         else
            next_state = FAIL;
      end
      if (next_state == RUN && WD_ENABLE && cycle_inc == WD_LIMIT)
         next_state = TMO;
   end

   // Verdict state machine with registered flags and diagnostics; terminal
   // states hold everything frozen until reset restarts checking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         timeout     <= 1'b0;
         store_count <= '0;
         cycle_count <= '0;
         fail_addr   <= '0;
         fail_data   <= '0;
      end else begin
         case (state)
            RUN: begin
               cycle_count <= cycle_inc;
               if (MemWrite)
                  store_count <= store_inc;
               state   <= next_state;
               done    <= (next_state != RUN);
               pass    <= (next_state == PASS);
               fail    <= (next_state == FAIL);
               timeout <= (next_state == TMO);
               if (next_state == FAIL) begin
                  fail_addr <= DataAddr;
                  fail_data <= WriteData;
               end
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // An unknown write strobe means the core under test is broken; flag it in
   // simulation rather than silently classifying garbage.
   always @(posedge clk) begin
      if (!reset)
         assert (!$isunknown(MemWrite))
         else $error("store_monitor: MemWrite is X/Z at time %0t", $time);
   end
`endif

endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor
// Directed bench for store_monitor: a monitor with a 50-cycle watchdog and a
// second one with the watchdog disabled share the same store stimulus.
module tb_store_monitor;

   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAddr;
   logic [31:0] WriteData;

   logic        done, pass, fail, timeout;
   logic [15:0] store_count, cycle_count;
   logic [31:0] fail_addr, fail_data;

   logic        done0, pass0, fail0, timeout0;
   logic [15:0] store_count0, cycle_count0;
   logic [31:0] fail_addr0, fail_data0;

   int checks;
   int failures;

   store_monitor #(.TIMEOUT(50)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAddr(DataAddr),
      .WriteData(WriteData), .done(done), .pass(pass), .fail(fail),
      .timeout(timeout), .store_count(store_count), .cycle_count(cycle_count),
      .fail_addr(fail_addr), .fail_data(fail_data)
   );

   store_monitor #(.TIMEOUT(0)) dut0 (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAddr(DataAddr),
      .WriteData(WriteData), .done(done0), .pass(pass0), .fail(fail0),
      .timeout(timeout0), .store_count(store_count0), .cycle_count(cycle_count0),
      .fail_addr(fail_addr0), .fail_data(fail_data0)
   );

   // Free-running 10 ns clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against the hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Present one store for a single rising edge, then sample 1 ns after it.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      MemWrite  = 1'b1;
      DataAddr  = addr;
      WriteData = data;
      @(posedge clk);
      #1;
      MemWrite  = 1'b0;
   endtask

   // Idle cycles with junk on the bus; MemWrite=0 must make them harmless.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         MemWrite  = 1'b0;
         DataAddr  = 32'd200;
         WriteData = 32'd5;
      end
      @(posedge clk);
      #1;
   endtask

   // Reset pulse released 2 ns after a falling edge, like the initial one.
   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      MemWrite  = 1'b0;
      DataAddr  = '0;
      WriteData = '0;
      #22;
      reset = 1'b0;

      // 1: scratch store then signature -> pass on the deciding edge
      checkOutput("reset_done", done, 0);
      checkOutput("reset_store_count", store_count, 0);
      applyStimulus(32'd96, 32'd7);
      checkOutput("t1_scratch_pass", pass, 0);
      checkOutput("t1_scratch_fail", fail, 0);
      checkOutput("t1_scratch_count", store_count, 1);
      applyStimulus(32'd100, 32'd25);
      checkOutput("t1_pass", pass, 1);
      checkOutput("t1_done", done, 1);
      checkOutput("t1_fail", fail, 0);
      checkOutput("t1_timeout", timeout, 0);
      checkOutput("t1_store_count", store_count, 2);
      checkOutput("t1_cycle_count", cycle_count, 3);
      applyStimulus(32'd200, 32'd5);
      idleCycles(3);
      checkOutput("t1_frozen_count", store_count, 2);
      checkOutput("t1_frozen_cycles", cycle_count, 3);
      checkOutput("t1_frozen_fail", fail, 0);

      // 2: wrong signature data
      doReset();
      idleCycles(2);
      checkOutput("t2_idle_junk_fail", fail, 0);
      applyStimulus(32'd100, 32'd24);
      checkOutput("t2_fail", fail, 1);
      checkOutput("t2_pass", pass, 0);
      checkOutput("t2_fail_addr", fail_addr, 100);
      checkOutput("t2_fail_data", fail_data, 24);

      // 2b: aligned store just below the scratch window
      doReset();
      applyStimulus(32'd92, 32'd3);
      checkOutput("t2b_fail", fail, 1);
      checkOutput("t2b_fail_addr", fail_addr, 92);

      // 3: illegal address, later signature ignored, first capture kept
      doReset();
      applyStimulus(32'd96, 32'd1);
      applyStimulus(32'd200, 32'd5);
      applyStimulus(32'd100, 32'd25);
      checkOutput("t3_fail", fail, 1);
      checkOutput("t3_pass", pass, 0);
      checkOutput("t3_fail_addr", fail_addr, 200);
      checkOutput("t3_fail_data", fail_data, 5);
      checkOutput("t3_store_count", store_count, 2);

      // 4: watchdog fires on the 50th edge after reset release
      doReset();
      repeat (49) @(posedge clk);
      #1;
      checkOutput("t4_before_timeout", timeout, 0);
      checkOutput("t4_before_cycles", cycle_count, 49);
      @(posedge clk);
      #1;
      checkOutput("t4_timeout", timeout, 1);
      checkOutput("t4_done", done, 1);
      checkOutput("t4_cycles", cycle_count, 50);
      checkOutput("t4_nowd_timeout", timeout0, 0);

      // 5: signature on the watchdog edge wins
      doReset();
      repeat (49) @(posedge clk);
      #1;
      checkOutput("t5_before_timeout", timeout, 0);
      applyStimulus(32'd100, 32'd25);
      checkOutput("t5_pass", pass, 1);
      checkOutput("t5_timeout", timeout, 0);
      checkOutput("t5_cycles", cycle_count, 50);

      // 6: misaligned store, then asynchronous reset mid-cycle
      doReset();
      applyStimulus(32'd98, 32'd0);
      checkOutput("t6_fail", fail, 1);
      checkOutput("t6_fail_addr", fail_addr, 98);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("t6_rst_done", done, 0);
      checkOutput("t6_rst_fail", fail, 0);
      checkOutput("t6_rst_fail_addr", fail_addr, 0);
      checkOutput("t6_rst_cycles", cycle_count, 0);
      checkOutput("t6_rst_count", store_count, 0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      applyStimulus(32'd100, 32'd25);
      checkOutput("t6_pass", pass, 1);
      checkOutput("t6_store_count", store_count, 1);

      // 7: watchdog disabled -> no timeout after 1000 cycles
      doReset();
      repeat (1000) @(posedge clk);
      #1;
      checkOutput("t7_nowd_timeout", timeout0, 0);
      checkOutput("t7_nowd_done", done0, 0);
      checkOutput("t7_nowd_cycles", cycle_count0, 1000);
      checkOutput("t7_wd_timeout", timeout, 1);
      checkOutput("t7_wd_cycles", cycle_count, 50);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
